q_serializer: RTL and testbench
===============================

# q_serializer

Charge-to-pulse-train transmitter: accepts a charge word, emits one pulse on `q_serialized` per `Q_PER_PULSE` charge quantum, then holds the line low long enough for the downstream measurement block's watchdog to expire. It is the transmit end of the serialized-charge link. It drives the pulse-count receiver in the test and loopback path, so `q_measured` at the far end equals `pulses_sent * Q_PER_PULSE`.

## Interface
- `BUS_WIDTH`, 10, width of the charge word, `pulses_sent` and `q_remainder`
- `Q_PER_PULSE`, 30, charge represented by one pulse; must be ≥1 and < 2**BUS_WIDTH
- `HIGH_CYCLES`, 1, clock cycles each pulse is high (≥1)
- `LOW_CYCLES`, 1, clock cycles low between pulses (≥1)
- `GAP_CYCLES`, 8, trailing low cycles after the burst; must exceed the receiver watchdog depth (2**WTD_BUS_WIDTH = 4) with margin

Ports:
- `clk`  in  1  single clock; all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `enable`  in  1  synchronous abort when low
- `q_in`  in  BUS_WIDTH  charge to transmit
- `in_valid`  in  1  `q_in` valid
- `in_ready`  out  1  block can accept a word
- `q_serialized`  out  1  pulse train, registered
- `busy`  out  1  transfer in progress
- `done`  out  1  one-cycle strobe at end of transfer
- `pulses_sent`  out  BUS_WIDTH  pulses emitted in current/last transfer
- `q_remainder`  out  BUS_WIDTH  untransmitted residue, `q_in mod Q_PER_PULSE`, valid from `done`

## Operation
- States: `IDLE`, `HIGH`, `LOW`, `GAP`, `DONE`.
- **`IDLE`:** `in_ready` is 1. On `in_valid && in_ready && enable`:
  - Load `residual <= q_in` and clear `pulses_sent`.
  - If `q_in >= Q_PER_PULSE`, go to `HIGH`; otherwise go to `GAP`.
- **`HIGH`:** `q_serialized` is 1 for `HIGH_CYCLES`.
  - On entry: `residual -= Q_PER_PULSE` and `pulses_sent += 1`.
  - Then go to `LOW`.
- **`LOW`:** `q_serialized` is 0 for `LOW_CYCLES`.
  - Then go to `HIGH` if `residual >= Q_PER_PULSE`; otherwise go to `GAP`.
- **`GAP`:** `q_serialized` is 0 for `GAP_CYCLES`, then go to `DONE`.
- **`DONE`:** `done` is 1 for exactly one cycle and `q_remainder <= residual`; then go to `IDLE`.
- Pulse count is floor(`q_in`/`Q_PER_PULSE`), computed by repeated subtraction; no divider.
- `residual` is BUS_WIDTH bits and never underflows, since a subtraction happens only when `residual >= Q_PER_PULSE`.
- A single phase counter, width `$clog2(max(HIGH_CYCLES, LOW_CYCLES, GAP_CYCLES)+1)`, is reloaded on every state entry.
- **`enable` low in any non-`IDLE` state:**
  - Next cycle: state is `IDLE`, `q_serialized` is 0, and `done` is not pulsed.
  - `pulses_sent` holds its partial count and `q_remainder` is unchanged.
  - `in_ready` is 0 while `enable` is low.
- **`in_valid` while not `IDLE`:** ignored. The sender must hold the word until it sees `in_ready`.

## Timing
- Reset values: state `IDLE`, `q_serialized` 0, `in_ready` 1, `busy` 0, `done` 0, `pulses_sent` 0, `q_remainder` 0.
- Let cycle 1 be the first cycle after the accepting edge.
  - First pulse rises in cycle 1.
  - `in_ready` is 0 and `busy` is 1 from cycle 1 through the `DONE` cycle.
- With P pulses, `done` is high in cycle 1 + P·(HIGH_CYCLES+LOW_CYCLES) + GAP_CYCLES.
- `in_ready` returns to 1 the cycle after `done`. Back-to-back transfers are therefore separated by ≥ GAP_CYCLES + 1 low cycles.
- `rst` overrides `enable` and all other inputs.

## Structure
- Shared package holds:
  - the state enum `q_ser_state_t`;
  - the default link constants `Q_PER_PULSE` and `BUS_WIDTH`, shared with the receiver so both ends agree.
- Add an `assert`/elaboration check that `GAP_CYCLES` exceeds the receiver watchdog depth.
- One sub-module, `phase_timer`, is natural: a loadable down-counter with a `zero` flag, used for the HIGH, LOW and GAP durations.

## Test plan
- Defaults, `q_in`=90: exactly 3 pulses, each 1 high / 1 low; `done` in cycle 15; `pulses_sent`=3, `q_remainder`=0.
- `q_in`=29: no pulse; `done` in cycle 9; `pulses_sent`=0, `q_remainder`=29.
- `q_in`=1023: 34 pulses, `q_remainder`=3. Loopback into the receiver yields `q_measured`=1020.
- `HIGH_CYCLES`=3, `LOW_CYCLES`=2, `q_in`=60: 2 pulses of 3 high, 2 low; `done` in cycle 19.
- `enable` dropped in cycle 4 of a `q_in`=90 transfer: `q_serialized` is 0 from cycle 5; no `done`; `pulses_sent`=2; next transfer accepted after `enable` returns.
- `rst` asserted mid-burst, with `in_valid` held high: all outputs are at reset values next cycle; a new transfer starts only after `rst` is released.

Source files
------------

// File: rtl/q_serializer_pkg.sv
// q_serializer_pkg: link constants, FSM state type and helpers for the serialized-charge link
package q_serializer_pkg;
   localparam int BUS_WIDTH     = 10;
   localparam int Q_PER_PULSE   = 30;
   localparam int WTD_BUS_WIDTH = 2;
   localparam int WTD_DEPTH     = 2 ** WTD_BUS_WIDTH;
   typedef enum logic [2:0] {IDLE, HIGH, LOW, GAP, DONE} q_ser_state_t;
   function automatic int max3(input int a, input int b, input int c);
      return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
   endfunction
endpackage

// File: rtl/q_serializer_phase_timer.sv
// phase_timer: loadable down-counter that flags zero, timing each FSM phase
// Ports: clk/rst, load_i + val_i reload the count, zero_o high when count is 0
module phase_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] val_i,
   output logic         zero_o
);
   logic [W-1:0] cnt_q;
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else if (load_i) cnt_q <= val_i;
      else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
   end
   assign zero_o = cnt_q == '0;
endmodule

// File: rtl/q_serializer.sv
// q_serializer: turns a charge word into one pulse per Q_PER_PULSE quantum, then a trailing low gap
// Ports: clk/rst, enable (abort when low), q_in/in_valid/in_ready handshake,
// q_serialized pulse line, busy, done strobe, pulses_sent and q_remainder results
module q_serializer #(
   parameter int BUS_WIDTH   = q_serializer_pkg::BUS_WIDTH,
   parameter int Q_PER_PULSE = q_serializer_pkg::Q_PER_PULSE,
   parameter int HIGH_CYCLES = 1,
   parameter int LOW_CYCLES  = 1,
   parameter int GAP_CYCLES  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [BUS_WIDTH-1:0] q_in,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 q_serialized,
   output logic                 busy,
   output logic                 done,
   output logic [BUS_WIDTH-1:0] pulses_sent,
   output logic [BUS_WIDTH-1:0] q_remainder
);
   import q_serializer_pkg::*;
   localparam int CW = $clog2(max3(HIGH_CYCLES, LOW_CYCLES, GAP_CYCLES) + 1);
   localparam logic [BUS_WIDTH-1:0] QPP = BUS_WIDTH'(Q_PER_PULSE);
   if (GAP_CYCLES <= WTD_DEPTH) begin : g_gap_chk
      $error("GAP_CYCLES must exceed the receiver watchdog depth");
   end
   if (Q_PER_PULSE < 1 || Q_PER_PULSE >= 2 ** BUS_WIDTH) begin : g_qpp_chk
      $error("Q_PER_PULSE out of range");
   end
   if (HIGH_CYCLES < 1 || LOW_CYCLES < 1) begin : g_cyc_chk
      $error("HIGH_CYCLES and LOW_CYCLES must be at least 1");
   end
   q_ser_state_t state_q, state_d;
   logic [BUS_WIDTH-1:0] res_q, pulses_q, rem_q;
   logic qs_q, done_q, tz, ld, acc, enter_high;
   logic [CW-1:0] ld_val;
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    state_d = (in_valid && enable) ? ((q_in >= QPP) ? HIGH : GAP) : IDLE;
         HIGH:    state_d = tz ? LOW : HIGH;
         LOW:     state_d = tz ? ((res_q >= QPP) ? HIGH : GAP) : LOW;
         GAP:     state_d = tz ? DONE : GAP;
         default: state_d = IDLE;
      endcase
      if (!enable) state_d = IDLE;
   end
   assign ld = state_d != state_q;
   assign ld_val = (state_d == HIGH) ? CW'(HIGH_CYCLES - 1) :
                   (state_d == LOW)  ? CW'(LOW_CYCLES - 1)  :
                   (state_d == GAP)  ? CW'(GAP_CYCLES - 1)  : '0;
   assign acc = state_q == IDLE && state_d != IDLE;
   assign enter_high = state_d == HIGH && state_q != HIGH;
   phase_timer #(.W(CW)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load_i (ld),
      .val_i  (ld_val),
      .zero_o (tz)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         res_q    <= '0;
         pulses_q <= '0;
         rem_q    <= '0;
         qs_q     <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         qs_q    <= state_d == HIGH;
         done_q  <= state_d == DONE;
         // a pulse is accounted the moment HIGH is entered, even straight from IDLE
         if (enter_high) begin
            res_q    <= (acc ? q_in : res_q) - QPP;
            pulses_q <= (acc ? '0 : pulses_q) + BUS_WIDTH'(1);
         end else if (acc) begin
            res_q    <= q_in;
            pulses_q <= '0;
         end
         if (state_d == DONE && state_q != DONE) rem_q <= res_q;
      end
   end
   assign in_ready     = state_q == IDLE && enable;
   assign busy         = state_q != IDLE;
   assign q_serialized = qs_q;
   assign done         = done_q;
   assign pulses_sent  = pulses_q;
   assign q_remainder  = rem_q;
endmodule

// File: tb/tb_q_serializer.sv
// tb_q_serializer: directed checks of pulse count, timing, abort and reset for q_serializer
module tb_q_serializer;
   logic clk = 1'b0, rst = 1'b1, enable = 1'b1;
   logic [9:0] q_in = '0, q_in2 = '0;
   logic in_valid = 1'b0, in_valid2 = 1'b0;
   logic rdy, qs, busy, done, rdy2, qs2, busy2, done2;
   logic [9:0] ps, rem, ps2, rem2;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   q_serializer dut (
      .clk(clk), .rst(rst), .enable(enable), .q_in(q_in), .in_valid(in_valid),
      .in_ready(rdy), .q_serialized(qs), .busy(busy), .done(done),
      .pulses_sent(ps), .q_remainder(rem)
   );
   q_serializer #(.HIGH_CYCLES(3), .LOW_CYCLES(2)) dut2 (
      .clk(clk), .rst(rst), .enable(enable), .q_in(q_in2), .in_valid(in_valid2),
      .in_ready(rdy2), .q_serialized(qs2), .busy(busy2), .done(done2),
      .pulses_sent(ps2), .q_remainder(rem2)
   );
   task automatic xfer(input bit sel, input logic [9:0] q, input int max_cyc,
                       output int done_cyc, output int rises, output int bad, output logic [31:0] wave);
      logic prev, s;
      done_cyc = 0; rises = 0; bad = 0; wave = '0; prev = 1'b0;
      @(negedge clk);
      if (sel) begin q_in2 = q; in_valid2 = 1'b1; end
      else begin q_in = q; in_valid = 1'b1; end
      @(posedge clk); #1;
      in_valid = 1'b0; in_valid2 = 1'b0;
      for (int c = 1; c <= max_cyc && done_cyc == 0; c++) begin
         @(negedge clk);
         s = sel ? qs2 : qs;
         if (c < 32) wave[c] = s;
         if (s && !prev) rises++;
         prev = s;
         if ((sel ? busy2 : busy) !== 1'b1 || (sel ? rdy2 : rdy) !== 1'b0) bad++;
         if ((sel ? done2 : done) === 1'b1) done_cyc = c;
      end
   endtask
   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (qs !== 1'b0) begin errors++; $display("FAIL reset_qs got %b want 0", qs); end
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", rdy); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (ps !== 10'd0) begin errors++; $display("FAIL reset_pulses got %0d want 0", ps); end
      checks++; if (rem !== 10'd0) begin errors++; $display("FAIL reset_rem got %0d want 0", rem); end
      rst = 1'b0;
   endtask
   task automatic test_basic;
      int dc, r, bad; logic [31:0] w;
      xfer(1'b0, 10'd90, 60, dc, r, bad, w);
      checks++; if (dc != 15) begin errors++; $display("FAIL basic_done_cycle got %0d want 15", dc); end
      checks++; if (r != 3) begin errors++; $display("FAIL basic_rises got %0d want 3", r); end
      checks++; if (w[14:1] !== 14'h0015) begin errors++; $display("FAIL basic_wave got %h want 0015", w[14:1]); end
      checks++; if (ps !== 10'd3) begin errors++; $display("FAIL basic_pulses got %0d want 3", ps); end
      checks++; if (rem !== 10'd0) begin errors++; $display("FAIL basic_rem got %0d want 0", rem); end
      checks++; if (bad != 0) begin errors++; $display("FAIL basic_busy_ready got %0d bad cycles want 0", bad); end
      @(negedge clk);
      checks++; if (rdy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL basic_after got rdy=%b done=%b want 1/0", rdy, done); end
   endtask
   task automatic test_small;
      int dc, r, bad; logic [31:0] w;
      xfer(1'b0, 10'd29, 60, dc, r, bad, w);
      checks++; if (dc != 9) begin errors++; $display("FAIL small_done_cycle got %0d want 9", dc); end
      checks++; if (r != 0) begin errors++; $display("FAIL small_rises got %0d want 0", r); end
      checks++; if (ps !== 10'd0) begin errors++; $display("FAIL small_pulses got %0d want 0", ps); end
      checks++; if (rem !== 10'd29) begin errors++; $display("FAIL small_rem got %0d want 29", rem); end
   endtask
   task automatic test_max;
      int dc, r, bad; logic [31:0] w;
      xfer(1'b0, 10'd1023, 200, dc, r, bad, w);
      checks++; if (dc != 77) begin errors++; $display("FAIL max_done_cycle got %0d want 77", dc); end
      checks++; if (ps !== 10'd34) begin errors++; $display("FAIL max_pulses got %0d want 34", ps); end
      checks++; if (rem !== 10'd3) begin errors++; $display("FAIL max_rem got %0d want 3", rem); end
      checks++; if (r * 30 != 1020) begin errors++; $display("FAIL max_loopback got %0d want 1020", r * 30); end
   endtask
   task automatic test_timing;
      int dc, r, bad; logic [31:0] w;
      xfer(1'b1, 10'd60, 80, dc, r, bad, w);
      checks++; if (dc != 19) begin errors++; $display("FAIL timing_done_cycle got %0d want 19", dc); end
      checks++; if (w[18:1] !== 18'h000E7) begin errors++; $display("FAIL timing_wave got %h want 000e7", w[18:1]); end
      checks++; if (ps2 !== 10'd2 || rem2 !== 10'd0) begin errors++; $display("FAIL timing_result got %0d/%0d want 2/0", ps2, rem2); end
   endtask
   task automatic test_abort;
      int dc, r, bad, seen; logic [31:0] w;
      @(negedge clk); q_in = 10'd90; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 enable = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++; if (qs !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_line got qs=%b busy=%b want 0/0", qs, busy); end
      checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL abort_in_ready got %b want 0", rdy); end
      checks++; if (ps !== 10'd2) begin errors++; $display("FAIL abort_pulses got %0d want 2", ps); end
      checks++; if (rem !== 10'd3) begin errors++; $display("FAIL abort_rem got %0d want 3", rem); end
      seen = 0;
      repeat (12) begin @(negedge clk); if (done === 1'b1 || qs === 1'b1) seen++; end
      checks++; if (seen != 0) begin errors++; $display("FAIL abort_quiet got %0d active cycles want 0", seen); end
      enable = 1'b1;
      @(negedge clk);
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL abort_ready_back got %b want 1", rdy); end
      xfer(1'b0, 10'd29, 60, dc, r, bad, w);
      checks++; if (dc != 9 || rem !== 10'd29) begin errors++; $display("FAIL abort_next got done=%0d rem=%0d want 9/29", dc, rem); end
   endtask
   task automatic test_rst_mid;
      int dc;
      @(negedge clk); q_in = 10'd90; in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++; if (qs !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rdy !== 1'b1)
         begin errors++; $display("FAIL rst_outputs got qs=%b busy=%b done=%b rdy=%b want 0/0/0/1", qs, busy, done, rdy); end
      checks++; if (ps !== 10'd0 || rem !== 10'd0) begin errors++; $display("FAIL rst_counts got %0d/%0d want 0/0", ps, rem); end
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_hold_busy got %b want 0", busy); end
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      checks++; if (qs !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rst_restart got qs=%b busy=%b want 1/1", qs, busy); end
      dc = 0;
      for (int c = 2; c <= 60 && dc == 0; c++) begin @(negedge clk); if (done === 1'b1) dc = c; end
      checks++; if (dc != 15) begin errors++; $display("FAIL rst_restart_done got %0d want 15", dc); end
   endtask
   initial begin
      test_reset();
      test_basic();
      test_small();
      test_max();
      test_timing();
      test_abort();
      test_rst_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
